// File: rtl/vga_pkg.sv
// Shared timing defaults, derived totals and datapath types for the VGA scan generator.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int WIN_W = 512;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int X_OFFSET_D = 64;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;

  typedef logic [8:0] rgb9_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic window;
  } scan_flags_t;

  // Value every flag stage holds out of reset: syncs idle high, blanked, no picture.
  localparam scan_flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, window: 1'b0};

  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counters with the frame-start pulse and vblank level.
module vga_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_D,
  parameter int V_TOTAL  = V_TOTAL_D,
  parameter int V_ACTIVE = V_ACTIVE_D
) (
  input  logic             pix_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_start,
  output logic             vblank
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
  logic [CNT_W-1:0] v_cnt_d, v_cnt_q;
  logic             frame_start_d, frame_start_q;
  logic             vblank_d, vblank_q;
  logic             h_wrap, v_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
    // Only a genuine raster wrap announces a frame; a reset-forced (0,0) never does.
    frame_start_d = h_wrap && v_wrap;
    vblank_d      = (v_cnt_d >= V_VIS);
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;

endmodule

// File: rtl/vga_scan.sv
// VGA scan generator: frame buffer pointer mapping (2x scaled, centred window),
// sync/blank flag delay line and the colour output mux, all aligned to 3 cycles.
module vga_scan
  import vga_pkg::*;
#(
  parameter int    H_ACTIVE   = H_ACTIVE_D,
  parameter int    H_FP       = H_FP_D,
  parameter int    H_SYNC     = H_SYNC_D,
  parameter int    H_BP       = H_BP_D,
  parameter int    V_ACTIVE   = V_ACTIVE_D,
  parameter int    V_FP       = V_FP_D,
  parameter int    V_SYNC     = V_SYNC_D,
  parameter int    V_BP       = V_BP_D,
  parameter int    X_OFFSET   = X_OFFSET_D,
  parameter rgb9_t BORDER_RGB = 9'h000
) (
  input  logic       pix_clk,
  input  logic       reset,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  logic [8:0] rgb,
  output logic [8:0] vga_rgb,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank,
  output logic       vblank,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(X_OFFSET + WIN_W);

  logic [CNT_W-1:0] h_cnt, v_cnt;

  vga_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .V_ACTIVE(V_ACTIVE)
  ) u_counter (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_start(frame_start),
    .vblank     (vblank)
  );

  logic        visible;
  scan_flags_t flags_p1_d, flags_p1_q;
  scan_flags_t flags_p2_d, flags_p2_q;
  logic [7:0]  ptr_x_p1_d, ptr_x_p1_q;
  logic [7:0]  ptr_y_p1_d, ptr_y_p1_q;
  logic        hs_p3_d, hs_p3_q;
  logic        vs_p3_d, vs_p3_q;
  logic        blank_p3_d, blank_p3_q;
  rgb9_t       rgb_p3_d, rgb_p3_q;

  // S0 -> S1: decode the raster position into flags and frame buffer pointers.
  always_comb begin
    visible          = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    flags_p1_d       = FLAGS_IDLE;
    flags_p1_d.hs    = !in_range(h_cnt, HS_START, HS_END);
    flags_p1_d.vs    = !in_range(v_cnt, VS_START, VS_END);
    flags_p1_d.blank = !visible;
    flags_p1_d.window = visible && in_range(h_cnt, WIN_LO, WIN_HI);
    ptr_x_p1_d       = '0;
    ptr_y_p1_d       = '0;
    if (flags_p1_d.window) begin
      ptr_x_p1_d = 8'((h_cnt - WIN_LO) >> 1);
      ptr_y_p1_d = 8'(v_cnt >> 1);
    end
  end

  // S1 -> S2: flags wait while the frame buffer registers its read.
  always_comb begin
    flags_p2_d = flags_p1_q;
  end

  // S2 -> S3: returned colour is only trusted inside the picture window.
  always_comb begin
    hs_p3_d    = flags_p2_q.hs;
    vs_p3_d    = flags_p2_q.vs;
    blank_p3_d = flags_p2_q.blank;
    if (flags_p2_q.blank) begin
      rgb_p3_d = '0;
    end else if (flags_p2_q.window) begin
      rgb_p3_d = rgb;
    end else begin
      rgb_p3_d = BORDER_RGB;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      ptr_x_p1_q <= '0;
      ptr_y_p1_q <= '0;
      flags_p1_q <= FLAGS_IDLE;
      flags_p2_q <= FLAGS_IDLE;
      hs_p3_q    <= 1'b1;
      vs_p3_q    <= 1'b1;
      blank_p3_q <= 1'b1;
      rgb_p3_q   <= '0;
    end else begin
      ptr_x_p1_q <= ptr_x_p1_d;
      ptr_y_p1_q <= ptr_y_p1_d;
      flags_p1_q <= flags_p1_d;
      flags_p2_q <= flags_p2_d;
      hs_p3_q    <= hs_p3_d;
      vs_p3_q    <= vs_p3_d;
      blank_p3_q <= blank_p3_d;
      rgb_p3_q   <= rgb_p3_d;
    end
  end

  assign pix_ptr_x = ptr_x_p1_q;
  assign pix_ptr_y = ptr_y_p1_q;
  assign vga_hs    = hs_p3_q;
  assign vga_vs    = vs_p3_q;
  assign vga_blank = blank_p3_q;
  assign vga_rgb   = rgb_p3_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan with a shortened vertical raster (14 lines) and full-width lines.
module tb_vga_scan;

  localparam int H_ACT = 640, H_TOT = 800;
  localparam int V_ACT = 8, V_TOT = 14;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int HS_LO = 656, HS_HI = 752, VS_LO = 10, VS_HI = 12;
  localparam int XO = 64;
  localparam logic [8:0] BORDER = 9'h1C0;
  localparam int WAIT_MAX = FRAME + 100;

  // Directed points: line, column, pointer x/y, blank, colour at the pins.
  localparam int NT = 15;
  localparam int TV[NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 6, 7, 8};
  localparam int TH[NT] = '{63, 64, 65, 66, 67, 100, 574, 575, 576, 640, 84, 319, 400, 575, 100};
  localparam int TX[NT] = '{0, 0, 0, 1, 1, 18, 255, 255, 0, 0, 10, 127, 168, 255, 0};
  localparam int TY[NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0};
  localparam logic TB_[NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  localparam logic [8:0] TRGB[NT] = '{9'h1C0, 9'h000, 9'h000, 9'h001, 9'h001, 9'h012,
                                      9'h03F, 9'h03F, 9'h1C0, 9'h000, 9'h04A, 9'h07F,
                                      9'h0E8, 9'h0FF, 9'h000};

  logic       pix_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb = 9'h000;
  logic [8:0] vga_rgb;
  logic       vga_hs, vga_vs, vga_blank, vblank, frame_start;

  int checks = 0;
  int failures = 0;

  always #5 pix_clk = ~pix_clk;

  vga_scan #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .X_OFFSET(64), .BORDER_RGB(9'h1C0)
  ) dut (
    .pix_clk    (pix_clk),
    .reset      (reset),
    .pix_ptr_x  (pix_ptr_x),
    .pix_ptr_y  (pix_ptr_y),
    .rgb        (rgb),
    .vga_rgb    (vga_rgb),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank  (vga_blank),
    .vblank     (vblank),
    .frame_start(frame_start)
  );

  // Frame buffer: one-cycle registered read of the pointers.
  always @(posedge pix_clk) rgb <= {pix_ptr_y[2:0], pix_ptr_x[5:0]};

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [8:0] rgb;
  } exp_t;

  localparam exp_t IDLE = '{h: 10'h3FF, v: 10'h3FF, hs: 1'b1, vs: 1'b1, blank: 1'b1, rgb: 9'h000};

  exp_t exp_q[$];
  int   mh = 0, mv = 0;
  int   hist_h[4], hist_v[4];
  int   hist_n = 0;
  logic exp_fs = 1'b0, exp_vb = 1'b0;
  logic [7:0] exp_px = 8'h00, exp_py = 8'h00;
  bit   model_on = 1'b0;

  function automatic exp_t expect_pins(input int h, input int v);
    exp_t e;
    bit vis, win;
    int x, y;
    vis = (h < H_ACT) && (v < V_ACT);
    win = vis && (h >= XO) && (h < XO + 512);
    x = (h - XO) / 2;
    y = v / 2;
    e.h = 10'(h);
    e.v = 10'(v);
    e.hs = !((h >= HS_LO) && (h < HS_HI));
    e.vs = !((v >= VS_LO) && (v < VS_HI));
    e.blank = !vis;
    if (!vis) e.rgb = 9'h000;
    else if (win) e.rgb = {3'(y), 6'(x)};
    else e.rgb = BORDER;
    return e;
  endfunction

  // Stimulus side of the scoreboard: track the raster and queue expected pin values.
  initial begin
    forever begin
      @(posedge pix_clk);
      #1;
      if (reset) begin
        exp_q.delete();
        repeat (3) exp_q.push_back(IDLE);
        mh = 0;
        mv = 0;
        hist_n = 0;
        exp_fs = 1'b0;
      end else begin
        if (mh == H_TOT - 1) begin
          mh = 0;
          mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
        exp_fs = (mh == 0) && (mv == 0);
      end
      for (int i = 3; i > 0; i--) begin
        hist_h[i] = hist_h[i-1];
        hist_v[i] = hist_v[i-1];
      end
      hist_h[0] = mh;
      hist_v[0] = mv;
      if (hist_n < 4) hist_n++;
      exp_vb = (mv >= V_ACT);
      exp_q.push_back(expect_pins(mh, mv));
      exp_px = 8'h00;
      exp_py = 8'h00;
      if (hist_n >= 2 && hist_h[1] >= XO && hist_h[1] < XO + 512 && hist_v[1] < V_ACT) begin
        exp_px = 8'((hist_h[1] - XO) / 2);
        exp_py = 8'(hist_v[1] / 2);
      end
      model_on = 1'b1;
    end
  end

  // Monitor: compare pins against the queue head, plus the undelayed outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge pix_clk);
      if (model_on) begin
        checks++;
        if ({frame_start, vblank} !== {exp_fs, exp_vb}) begin
          failures++;
          $display("FAIL fs_vb at h=%0d v=%0d: got fs=%b vb=%b want fs=%b vb=%b",
                   mh, mv, frame_start, vblank, exp_fs, exp_vb);
        end
        checks++;
        if ({pix_ptr_x, pix_ptr_y} !== {exp_px, exp_py}) begin
          failures++;
          $display("FAIL ptr at h=%0d v=%0d: got x=%0d y=%0d want x=%0d y=%0d",
                   mh, mv, pix_ptr_x, pix_ptr_y, exp_px, exp_py);
        end
        if (exp_q.size() >= 4) begin
          e = exp_q.pop_front();
          checks++;
          if ({vga_hs, vga_vs, vga_blank, vga_rgb} !== {e.hs, e.vs, e.blank, e.rgb}) begin
            failures++;
            $display("FAIL pins for h=%0d v=%0d: got hs=%b vs=%b blank=%b rgb=%h want hs=%b vs=%b blank=%b rgb=%h",
                     e.h, e.v, vga_hs, vga_vs, vga_blank, vga_rgb, e.hs, e.vs, e.blank, e.rgb);
          end
        end
      end
    end
  end

  task automatic check_first_fs(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(posedge pix_clk);
    while (n < FRAME + 10) begin
      @(negedge pix_clk);
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge pix_clk);
      n++;
    end
    checks++;
    if (!seen || n != FRAME - 1) begin
      failures++;
      $display("FAIL %s first_fs: got %0d cycles (seen=%0b) want %0d", tag, n, seen, FRAME - 1);
    end
  endtask

  task automatic run_ptr_table();
    for (int k = 0; k < NT; k++) begin
      int n;
      n = 0;
      while (!(hist_n >= 2 && hist_h[1] == TH[k] && hist_v[1] == TV[k]) && n < WAIT_MAX) begin
        @(negedge pix_clk);
        n++;
      end
      checks++;
      if (n >= WAIT_MAX) begin
        failures++;
        $display("FAIL ptr_tab[%0d] timeout waiting for h=%0d v=%0d", k, TH[k], TV[k]);
        return;
      end
      if (pix_ptr_x !== 8'(TX[k]) || pix_ptr_y !== 8'(TY[k])) begin
        failures++;
        $display("FAIL ptr_tab[%0d] h=%0d v=%0d: got x=%0d y=%0d want x=%0d y=%0d",
                 k, TH[k], TV[k], pix_ptr_x, pix_ptr_y, TX[k], TY[k]);
      end
    end
  endtask

  task automatic run_pin_table();
    for (int k = 0; k < NT; k++) begin
      int n;
      n = 0;
      while (!(hist_n >= 4 && hist_h[3] == TH[k] && hist_v[3] == TV[k]) && n < WAIT_MAX) begin
        @(negedge pix_clk);
        n++;
      end
      checks++;
      if (n >= WAIT_MAX) begin
        failures++;
        $display("FAIL pin_tab[%0d] timeout waiting for h=%0d v=%0d", k, TH[k], TV[k]);
        return;
      end
      if (vga_blank !== TB_[k] || vga_rgb !== TRGB[k]) begin
        failures++;
        $display("FAIL pin_tab[%0d] h=%0d v=%0d: got blank=%b rgb=%h want blank=%b rgb=%h",
                 k, TH[k], TV[k], vga_blank, vga_rgb, TB_[k], TRGB[k]);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Starts on the frame_start cycle and walks exactly one frame.
  task automatic run_frame_check();
    int hs_pulses, hs_run, vs_low, vs_falls, vs_first, fs_cnt;
    logic hs_prev, vs_prev;
    hs_pulses = 0; hs_run = 0; vs_low = 0; vs_falls = 0; vs_first = -1; fs_cnt = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    check("wrap_vblank_low", int'(vblank), 0);
    for (int i = 0; i < FRAME; i++) begin
      if (vga_hs === 1'b0) begin
        if (hs_prev) hs_pulses++;
        hs_run++;
      end else if (!hs_prev) begin
        check("hs_width", hs_run, 96);
        hs_run = 0;
      end
      if (vga_vs === 1'b0) begin
        vs_low++;
        if (vs_prev) begin
          vs_falls++;
          if (vs_first < 0) vs_first = i;
        end
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (i == 1) check("fs_one_cycle", int'(frame_start), 0);
      if (i == FRAME - 1) check("vblank_before_wrap", int'(vblank), 1);
      hs_prev = vga_hs;
      vs_prev = vga_vs;
      @(negedge pix_clk);
    end
    check("hs_pulses", hs_pulses, V_TOT);
    check("vs_low_cycles", vs_low, 2 * H_TOT);
    check("vs_pulses", vs_falls, 1);
    check("vs_start", vs_first, VS_LO * H_TOT + 3);
    check("fs_per_frame", fs_cnt, 1);
    check("fs_period", int'(frame_start), 1);
    check("vblank_fall_on_wrap", int'(vblank), 0);
  endtask

  initial begin
    #(10 * 70000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (5) @(negedge pix_clk);
    reset = 1'b0;
    fork
      check_first_fs("boot");
      run_ptr_table();
      run_pin_table();
    join
    run_frame_check();

    n = 0;
    while (!(mh == 300 && mv == 5) && n < WAIT_MAX) begin
      @(negedge pix_clk);
      n++;
    end
    check("reach_mid_frame", int'(n < WAIT_MAX), 1);
    reset = 1'b1;
    @(negedge pix_clk);
    reset = 1'b0;
    check("mid_reset_hs", int'(vga_hs), 1);
    check("mid_reset_vs", int'(vga_vs), 1);
    check("mid_reset_blank", int'(vga_blank), 1);
    check("mid_reset_rgb", int'(vga_rgb), 0);
    check("mid_reset_fs", int'(frame_start), 0);
    check("mid_reset_ptr", int'({pix_ptr_x, pix_ptr_y}), 0);
    check_first_fs("mid_reset");

    repeat (5) @(negedge pix_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
